eth_reset_monitor: RTL and testbench
====================================

# eth_reset_monitor

Observer for the Ethernet PHY reset sequence: watches the reset trigger, the PHY reset line and link status. For each reset it measures trigger-to-assertion delay, pulse width and release-to-link time, classifies the outcome, and presents one status record per reset on a valid/ready output. It sits beside the one-shot reset generator on the same trigger and reset nets and checks the generator's output and the PHY's recovery.

## Interface
- TIMER_MAX_WIDTH, 14, width of the delay counter and MeasuredDelay
- RESET_MAX_WIDTH, 14, width of the pulse-width counter, MinWidth and MeasuredWidth
- LINK_TIMEOUT_WIDTH, 20, width of the link-wait counter, LinkTimeout and MeasuredLinkTime
- RESETLOGIC, 0, active level of ResetTrigger

- clk  in  1  sole clock; all logic on posedge
- areset  in  1  synchronous, active-high reset
- ResetTrigger  in  1  trigger; active when equal to RESETLOGIC
- ObservedReset  in  1  PHY reset line, active-high
- LinkUp  in  1  PHY link status, high = up
- MinWidth  in  RESET_MAX_WIDTH  minimum acceptable pulse width, cycles
- LinkTimeout  in  LINK_TIMEOUT_WIDTH  link-wait limit, cycles; 0 disables the link wait
- MeasuredDelay  out  TIMER_MAX_WIDTH  trigger-to-assertion cycles
- MeasuredWidth  out  RESET_MAX_WIDTH  assertion cycles
- MeasuredLinkTime  out  LINK_TIMEOUT_WIDTH  release-to-link cycles
- Status  out  3  outcome code
- StatusValid  out  1  record valid
- StatusReady  in  1  consumer accepts the record
- Busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, ARMED, PULSE, LINKWAIT, REPORT.
- Status codes:
  - 0 OK
  - 1 NO_ASSERT
  - 2 SHORT
  - 3 STUCK
  - 4 LINK_TIMEOUT
  - 5 UNSOLICITED
  - 6–7 are never produced.
- IDLE:
  - Trigger active and ObservedReset low: go to ARMED with the delay counter at 0.
  - Trigger active and ObservedReset high: solicited reset with delay 0; go to PULSE with the width counter at 1.
  - ObservedReset high and trigger inactive: unsolicited; delay 0, go to PULSE with the width counter at 1, unsolicited flag set.
- ARMED:
  - The delay counter increments each cycle.
  - When ObservedReset is sampled high: MeasuredDelay = delay counter + 1, width counter = 1, go to PULSE.
  - If the counter reaches all-ones with ObservedReset still low: Status 1, width 0, link time 0, go to REPORT.
- PULSE:
  - The width counter increments while ObservedReset is high.
  - On the first low sample: MeasuredWidth = the count.
  - If the width counter reaches all-ones while ObservedReset is still high: Status 3, go to REPORT.
- After PULSE ends with ObservedReset low:
  - Width < MinWidth: Status 2, skip LINKWAIT.
  - Else, LinkTimeout == 0: Status 0 (or 5 if unsolicited), link time 0.
  - Else go to LINKWAIT with the link counter at 0.
- LINKWAIT:
  - The link counter increments each cycle.
  - LinkUp sampled high: MeasuredLinkTime = count + 1, Status 0 (or 5 if unsolicited).
  - Count + 1 == LinkTimeout with LinkUp still low: Status 4, MeasuredLinkTime = LinkTimeout.
- Status precedence: SHORT, STUCK and LINK_TIMEOUT override UNSOLICITED.
- REPORT:
  - StatusValid is high.
  - All Measured* outputs and Status are frozen until the cycle StatusValid && StatusReady; the transfer completes in that cycle.
  - Next cycle: IDLE, StatusValid low.
  - Measured* and Status then keep their last values until overwritten.
- Triggers and ObservedReset activity are ignored outside IDLE, except as the states above describe. A trigger held active across the return to IDLE starts a new record.
- Counters saturate; they never wrap.
- MinWidth and LinkTimeout are sampled each cycle and must be held stable while Busy is high.

## Timing
- areset (synchronous, active-high) puts every output at 0 (StatusValid 0, Busy 0, Status 0, all Measured* 0) and the state at IDLE on the next edge. This applies in any state, including mid-pulse and mid-REPORT; a pending record is discarded.
- Busy rises the cycle after the trigger sample.
- StatusValid rises one cycle after the terminating sample: the low sample of ObservedReset, the high sample of LinkUp, or counter saturation/timeout.
- A LinkUp that is already high when the pulse ends is sampled on the first LINKWAIT cycle, giving MeasuredLinkTime = 1.
- StatusValid never drops without a handshake, except on areset.

## Configuration
- ETH_RESET_MON_STICKY_ERR_EN defined:
  - Adds output ErrorSticky (1 bit).
  - It sets on any accepted record whose Status != 0 and clears only on areset.
  - Reset value 0.
- Undefined: the port and its logic are absent; the rest of the behaviour is identical.

## Test plan
- Nominal: MinWidth 20, LinkTimeout 1000; trigger sampled at cycle 10, ObservedReset first high at 110, held 50 cycles, LinkUp 200 cycles after the first low sample -> Delay 100, Width 50, LinkTime 200, Status 0, StatusValid held until Ready.
- Short pulse: 5-cycle pulse with MinWidth 20 -> Status 2, Width 5, LinkTime 0, no link wait.
- Missing assertion: TIMER_MAX_WIDTH 8, trigger with ObservedReset never high -> Status 1, Delay 255.
- Link timeout: LinkTimeout 300, LinkUp never rises -> Status 4, LinkTime 300. With the macro defined, ErrorSticky = 1 after the handshake.
- Unsolicited: 30-cycle ObservedReset pulse in IDLE with no trigger and LinkTimeout 0 -> Status 5, Delay 0, Width 30.
- Backpressure and reset:
  - StatusReady held low 20 cycles -> outputs stable, StatusValid high throughout.
  - Separately, areset mid-PULSE -> all outputs 0, IDLE, and no record produced.

Source files
------------

// File: rtl/eth_reset_monitor.sv
`default_nettype none
// ============================================================================
// Module   : eth_reset_monitor
// Brief    : Observer for the Ethernet PHY reset sequence. For each reset it
//            measures trigger-to-assertion delay, pulse width and
//            release-to-link time, classifies the outcome and presents one
//            status record per reset on a valid/ready output.
// Options  : ETH_RESET_MON_STICKY_ERR_EN adds the ErrorSticky output.
// Revision : 1.0 - initial release
// ============================================================================
module eth_reset_monitor #(
  parameter int TIMER_MAX_WIDTH    = 14,
  parameter int RESET_MAX_WIDTH    = 14,
  parameter int LINK_TIMEOUT_WIDTH = 20,
  parameter int RESETLOGIC         = 0
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic                          ResetTrigger,
  input  logic                          ObservedReset,
  input  logic                          LinkUp,
  input  logic [RESET_MAX_WIDTH-1:0]    MinWidth,
  input  logic [LINK_TIMEOUT_WIDTH-1:0] LinkTimeout,
  output logic [TIMER_MAX_WIDTH-1:0]    MeasuredDelay,
  output logic [RESET_MAX_WIDTH-1:0]    MeasuredWidth,
  output logic [LINK_TIMEOUT_WIDTH-1:0] MeasuredLinkTime,
  output logic [2:0]                    Status,
  output logic                          StatusValid,
  input  logic                          StatusReady,
  output logic                          Busy
`ifdef ETH_RESET_MON_STICKY_ERR_EN
  ,
  output logic                          ErrorSticky
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_PULSE    = 3'd2,
    S_LINKWAIT = 3'd3,
    S_REPORT   = 3'd4
  } state_t;

  localparam logic [2:0] c_ST_OK           = 3'd0;
  localparam logic [2:0] c_ST_NO_ASSERT    = 3'd1;
  localparam logic [2:0] c_ST_SHORT        = 3'd2;
  localparam logic [2:0] c_ST_STUCK        = 3'd3;
  localparam logic [2:0] c_ST_LINK_TIMEOUT = 3'd4;
  localparam logic [2:0] c_ST_UNSOLICITED  = 3'd5;

  localparam logic [TIMER_MAX_WIDTH-1:0]    c_T_ONE  = 1;
  localparam logic [TIMER_MAX_WIDTH-1:0]    c_T_MAX  = '1;
  localparam logic [RESET_MAX_WIDTH-1:0]    c_R_ONE  = 1;
  localparam logic [RESET_MAX_WIDTH-1:0]    c_R_MAX  = '1;
  localparam logic [LINK_TIMEOUT_WIDTH-1:0] c_L_ONE  = 1;
  localparam logic [LINK_TIMEOUT_WIDTH-1:0] c_L_ZERO = '0;
  localparam logic                          c_TRIG_LVL = (RESETLOGIC != 0);

  state_t                          r_state, w_state_nxt;
  logic [TIMER_MAX_WIDTH-1:0]      r_delay, w_delay_nxt;
  logic [RESET_MAX_WIDTH-1:0]      r_width, w_width_nxt;
  logic [LINK_TIMEOUT_WIDTH-1:0]   r_link,  w_link_nxt;
  logic [2:0]                      r_code,  w_code_nxt;
  logic                            r_unsol, w_unsol_nxt;

  logic [TIMER_MAX_WIDTH-1:0]      r_out_delay;
  logic [RESET_MAX_WIDTH-1:0]      r_out_width;
  logic [LINK_TIMEOUT_WIDTH-1:0]   r_out_link;
  logic [2:0]                      r_out_status;

  logic                            w_trig_act;
  logic [2:0]                      w_good_code;
  logic                            w_load;
  logic                            w_accept;

  assign w_trig_act  = (ResetTrigger == c_TRIG_LVL);
  // A clean sequence is still flagged when nobody asked for the reset.
  assign w_good_code = r_unsol ? c_ST_UNSOLICITED : c_ST_OK;
  // Output record is captured once, on the transition into REPORT, so the
  // Measured* outputs only ever change when a new record is presented.
  assign w_load      = (w_state_nxt == S_REPORT) && (r_state != S_REPORT);
  assign w_accept    = (r_state == S_REPORT) && StatusReady;

  assign MeasuredDelay    = r_out_delay;
  assign MeasuredWidth    = r_out_width;
  assign MeasuredLinkTime = r_out_link;
  assign Status           = r_out_status;
  assign StatusValid      = (r_state == S_REPORT);
  assign Busy             = (r_state != S_IDLE);

  // Next-state and counter logic; counters stop one short of wrapping.
  always_comb begin
    w_state_nxt = r_state;
    w_delay_nxt = r_delay;
    w_width_nxt = r_width;
    w_link_nxt  = r_link;
    w_code_nxt  = r_code;
    w_unsol_nxt = r_unsol;
    case (r_state)
      S_IDLE: begin
        if (ObservedReset) begin
          // Reset already asserted: solicited with zero delay, or unsolicited.
          w_delay_nxt = '0;
          w_width_nxt = c_R_ONE;
          w_link_nxt  = '0;
          w_code_nxt  = c_ST_OK;
          w_unsol_nxt = !w_trig_act;
          w_state_nxt = S_PULSE;
        end else if (w_trig_act) begin
          w_delay_nxt = '0;
          w_width_nxt = '0;
          w_link_nxt  = '0;
          w_code_nxt  = c_ST_OK;
          w_unsol_nxt = 1'b0;
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (ObservedReset) begin
          w_delay_nxt = r_delay + c_T_ONE;
          w_width_nxt = c_R_ONE;
          w_state_nxt = S_PULSE;
        end else if (r_delay + c_T_ONE == c_T_MAX) begin
          w_delay_nxt = c_T_MAX;
          w_width_nxt = '0;
          w_link_nxt  = '0;
          w_code_nxt  = c_ST_NO_ASSERT;
          w_state_nxt = S_REPORT;
        end else begin
          w_delay_nxt = r_delay + c_T_ONE;
        end
      end
      S_PULSE: begin
        if (ObservedReset) begin
          if (r_width + c_R_ONE == c_R_MAX) begin
            w_width_nxt = c_R_MAX;
            w_link_nxt  = '0;
            w_code_nxt  = c_ST_STUCK;
            w_state_nxt = S_REPORT;
          end else begin
            w_width_nxt = r_width + c_R_ONE;
          end
        end else if (r_width < MinWidth) begin
          w_link_nxt  = '0;
          w_code_nxt  = c_ST_SHORT;
          w_state_nxt = S_REPORT;
        end else if (LinkTimeout == c_L_ZERO) begin
          w_link_nxt  = '0;
          w_code_nxt  = w_good_code;
          w_state_nxt = S_REPORT;
        end else begin
          w_link_nxt  = '0;
          w_state_nxt = S_LINKWAIT;
        end
      end
      S_LINKWAIT: begin
        if (LinkUp) begin
          w_link_nxt  = r_link + c_L_ONE;
          w_code_nxt  = w_good_code;
          w_state_nxt = S_REPORT;
        end else if (r_link + c_L_ONE == LinkTimeout) begin
          w_link_nxt  = LinkTimeout;
          w_code_nxt  = c_ST_LINK_TIMEOUT;
          w_state_nxt = S_REPORT;
        end else begin
          w_link_nxt  = r_link + c_L_ONE;
        end
      end
      S_REPORT: begin
        if (StatusReady) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and the captured output record.
  always_ff @(posedge clk) begin
    if (areset) begin
      r_state      <= S_IDLE;
      r_delay      <= '0;
      r_width      <= '0;
      r_link       <= '0;
      r_code       <= c_ST_OK;
      r_unsol      <= 1'b0;
      r_out_delay  <= '0;
      r_out_width  <= '0;
      r_out_link   <= '0;
      r_out_status <= c_ST_OK;
    end else begin
      r_state <= w_state_nxt;
      r_delay <= w_delay_nxt;
      r_width <= w_width_nxt;
      r_link  <= w_link_nxt;
      r_code  <= w_code_nxt;
      r_unsol <= w_unsol_nxt;
      if (w_load) begin
        r_out_delay  <= w_delay_nxt;
        r_out_width  <= w_width_nxt;
        r_out_link   <= w_link_nxt;
        r_out_status <= w_code_nxt;
      end
    end
  end

`ifdef ETH_RESET_MON_STICKY_ERR_EN
  logic r_sticky;
  assign ErrorSticky = r_sticky;

  // Latch any non-OK record once the consumer has taken it.
  always_ff @(posedge clk) begin
    if (areset) begin
      r_sticky <= 1'b0;
    end else if (w_accept && (r_out_status != c_ST_OK)) begin
      r_sticky <= 1'b1;
    end
  end
`else
  logic w_accept_unused;
  assign w_accept_unused = w_accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_reset_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_reset_monitor
// Brief    : Directed self-checking bench for eth_reset_monitor.
//            Honours ETH_RESET_MON_STICKY_ERR_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_reset_monitor;

  localparam int TW = 8;
  localparam int RW = 8;
  localparam int LW = 20;

  logic          clk = 1'b0;
  logic          areset;
  logic          ResetTrigger;
  logic          ObservedReset;
  logic          LinkUp;
  logic [RW-1:0] MinWidth;
  logic [LW-1:0] LinkTimeout;
  logic [TW-1:0] MeasuredDelay;
  logic [RW-1:0] MeasuredWidth;
  logic [LW-1:0] MeasuredLinkTime;
  logic [2:0]    Status;
  logic          StatusValid;
  logic          StatusReady;
  logic          Busy;
`ifdef ETH_RESET_MON_STICKY_ERR_EN
  logic          ErrorSticky;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // 100 MHz clock
  always #5 clk = ~clk;

  eth_reset_monitor #(
    .TIMER_MAX_WIDTH    (TW),
    .RESET_MAX_WIDTH    (RW),
    .LINK_TIMEOUT_WIDTH (LW),
    .RESETLOGIC         (0)
  ) dut (
    .clk              (clk),
    .areset           (areset),
    .ResetTrigger     (ResetTrigger),
    .ObservedReset    (ObservedReset),
    .LinkUp           (LinkUp),
    .MinWidth         (MinWidth),
    .LinkTimeout      (LinkTimeout),
    .MeasuredDelay    (MeasuredDelay),
    .MeasuredWidth    (MeasuredWidth),
    .MeasuredLinkTime (MeasuredLinkTime),
    .Status           (Status),
    .StatusValid      (StatusValid),
    .StatusReady      (StatusReady),
    .Busy             (Busy)
`ifdef ETH_RESET_MON_STICKY_ERR_EN
    ,
    .ErrorSticky      (ErrorSticky)
`endif
  );

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rec(input string tag, input logic [31:0] st, input logic [31:0] dly,
                           input logic [31:0] wid, input logic [31:0] lnk);
    check({tag, ".valid"},  32'(StatusValid),      32'd1);
    check({tag, ".status"}, 32'(Status),           st);
    check({tag, ".delay"},  32'(MeasuredDelay),    dly);
    check({tag, ".width"},  32'(MeasuredWidth),    wid);
    check({tag, ".link"},   32'(MeasuredLinkTime), lnk);
  endtask

  task automatic handshake();
    StatusReady = 1'b1;
    tick(1);
    StatusReady = 1'b0;
  endtask

  // Solicited reset with the PHY line already high at the trigger sample.
  task automatic trig_with_pulse();
    ResetTrigger  = 1'b0;
    ObservedReset = 1'b1;
    tick(1);
    ResetTrigger  = 1'b1;
  endtask

  initial begin
    areset        = 1'b1;
    ResetTrigger  = 1'b1;
    ObservedReset = 1'b0;
    LinkUp        = 1'b0;
    MinWidth      = 8'd20;
    LinkTimeout   = 20'd1000;
    StatusReady   = 1'b0;
    tick(3);
    check("rst.valid",  32'(StatusValid),      32'd0);
    check("rst.busy",   32'(Busy),             32'd0);
    check("rst.status", 32'(Status),           32'd0);
    check("rst.delay",  32'(MeasuredDelay),    32'd0);
    check("rst.width",  32'(MeasuredWidth),    32'd0);
    check("rst.link",   32'(MeasuredLinkTime), 32'd0);
`ifdef ETH_RESET_MON_STICKY_ERR_EN
    check("rst.sticky", 32'(ErrorSticky), 32'd0);
`endif
    areset = 1'b0;
    tick(2);
    check("idle.busy", 32'(Busy), 32'd0);

    // Nominal: delay 100, width 50, link 200
    ResetTrigger = 1'b0;
    tick(1);
    ResetTrigger = 1'b1;
    check("nom.busy_rise", 32'(Busy), 32'd1);
    tick(99);
    check("nom.armed_valid", 32'(StatusValid), 32'd0);
    ObservedReset = 1'b1;
    tick(50);
    ObservedReset = 1'b0;
    tick(200);
    check("nom.wait_valid", 32'(StatusValid), 32'd0);
    LinkUp = 1'b1;
    tick(1);
    check_rec("nom", 32'd0, 32'd100, 32'd50, 32'd200);
    LinkUp = 1'b0;
    tick(5);
    check("nom.hold_valid", 32'(StatusValid),   32'd1);
    check("nom.hold_delay", 32'(MeasuredDelay), 32'd100);
    handshake();
    check("nom.done_valid", 32'(StatusValid),      32'd0);
    check("nom.done_busy",  32'(Busy),             32'd0);
    check("nom.kept_link",  32'(MeasuredLinkTime), 32'd200);
`ifdef ETH_RESET_MON_STICKY_ERR_EN
    check("nom.sticky", 32'(ErrorSticky), 32'd0);
`endif

    // Short pulse: 5 cycles against MinWidth 20, no link wait
    trig_with_pulse();
    tick(4);
    ObservedReset = 1'b0;
    tick(1);
    check_rec("short", 32'd2, 32'd0, 32'd5, 32'd0);
    handshake();
`ifdef ETH_RESET_MON_STICKY_ERR_EN
    check("short.sticky", 32'(ErrorSticky), 32'd1);
`endif

    // Unsolicited: 30-cycle pulse, link wait disabled
    LinkTimeout   = 20'd0;
    ObservedReset = 1'b1;
    tick(30);
    ObservedReset = 1'b0;
    tick(1);
    check_rec("unsol", 32'd5, 32'd0, 32'd30, 32'd0);
    handshake();
    LinkTimeout = 20'd1000;

    // Missing assertion: delay saturates at 255
    ResetTrigger = 1'b0;
    tick(1);
    ResetTrigger = 1'b1;
    tick(254);
    check("noassert.early_valid", 32'(StatusValid), 32'd0);
    tick(1);
    check_rec("noassert", 32'd1, 32'd255, 32'd0, 32'd0);
    handshake();

    // LinkUp already high at pulse end -> link time 1
    trig_with_pulse();
    tick(24);
    LinkUp        = 1'b1;
    ObservedReset = 1'b0;
    tick(1);
    check("linkhi.wait_valid", 32'(StatusValid), 32'd0);
    tick(1);
    check_rec("linkhi", 32'd0, 32'd0, 32'd25, 32'd1);
    LinkUp = 1'b0;
    handshake();

    // Link timeout 300, width exactly MinWidth (not short)
    LinkTimeout = 20'd300;
    trig_with_pulse();
    tick(19);
    ObservedReset = 1'b0;
    tick(1);
    check("lto.linkwait_busy",  32'(Busy),        32'd1);
    check("lto.linkwait_valid", 32'(StatusValid), 32'd0);
    tick(299);
    check("lto.early_valid", 32'(StatusValid), 32'd0);
    tick(1);
    check_rec("lto", 32'd4, 32'd0, 32'd20, 32'd300);
    // Backpressure: record frozen for 20 cycles, trigger ignored meanwhile
    ResetTrigger = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check_rec("bp", 32'd4, 32'd0, 32'd20, 32'd300);
    end
    ResetTrigger = 1'b1;
    handshake();
    check("lto.done_valid", 32'(StatusValid), 32'd0);
`ifdef ETH_RESET_MON_STICKY_ERR_EN
    check("lto.sticky", 32'(ErrorSticky), 32'd1);
`endif
    LinkTimeout = 20'd1000;

    // Stuck: width counter saturates at 255 while still high
    trig_with_pulse();
    tick(253);
    check("stuck.early_valid", 32'(StatusValid), 32'd0);
    tick(1);
    check_rec("stuck", 32'd3, 32'd0, 32'd255, 32'd0);
    ObservedReset = 1'b0;
    handshake();

    // areset mid-PULSE discards everything
    trig_with_pulse();
    tick(10);
    check("arst.pre_busy", 32'(Busy), 32'd1);
    areset = 1'b1;
    tick(1);
    check("arst.valid",  32'(StatusValid),      32'd0);
    check("arst.busy",   32'(Busy),             32'd0);
    check("arst.status", 32'(Status),           32'd0);
    check("arst.delay",  32'(MeasuredDelay),    32'd0);
    check("arst.width",  32'(MeasuredWidth),    32'd0);
    check("arst.link",   32'(MeasuredLinkTime), 32'd0);
`ifdef ETH_RESET_MON_STICKY_ERR_EN
    check("arst.sticky", 32'(ErrorSticky), 32'd0);
`endif
    areset        = 1'b0;
    ObservedReset = 1'b0;
    tick(5);
    check("arst.after_valid", 32'(StatusValid), 32'd0);
    check("arst.after_busy",  32'(Busy),        32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
